// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the memory responder: RV32I load/store width
// codes, FSM state type and the func3 legality rule.
package mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  // Unsigned widths only make sense for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic wr);
    logic ill;
    case (f3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = wr;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for
// loads; also flags half/word accesses that are not naturally aligned.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o       = '0;
    wdata_o    = wdata_i;
    rdata_o    = '0;
    misalign_o = 1'b0;
    shifted    = rdword_i >> {addr_lo_i, 3'b000};
    case (func3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = func3_i[2] ? {24'h0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = func3_i[2] ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        misalign_o = |addr_lo_i;
        be_o       = 4'b1111;
        rdata_o    = rdword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory target: valid/ready request, fixed wait states,
// byte/half/word access with error flagging, response held until taken.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic        a_wr;
  logic [2:0]  a_f3;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] rext;
  logic        misalign;
  logic        oob;
  logic        acc_err;
  logic        acc_fire;
  logic        mem_we;

  // With LATENCY==1 the access happens on the accept edge, before the latch
  // holds anything, so the access path reads the live request while idle.
  always_comb begin
    if (state_q == S_IDLE) begin
      a_wr    = req_write;
      a_f3    = req_func3;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end else begin
      a_wr    = wr_q;
      a_f3    = f3_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  assign idx     = a_addr[AW+1:2];
  assign oob     = (a_addr[31:2] >= 30'(DEPTH));
  assign acc_err = misalign | oob | f3_illegal(a_f3, a_wr);

  mem_lane_align u_align (
    .func3_i   (a_f3),
    .addr_lo_i (a_addr[1:0]),
    .wdata_i   (a_wdata),
    .rdword_i  (mem[idx]),
    .be_o      (be),
    .wdata_o   (wlane),
    .rdata_o   (rext),
    .misalign_o(misalign)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    acc_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          f3_d    = req_func3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            acc_fire = 1'b1;
            state_d  = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          acc_fire = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (acc_fire) begin
      err_d   = acc_err;
      rdata_d = (acc_err || a_wr) ? '0 : rext;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_we = acc_fire & a_wr & ~acc_err & ~clr;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: byte-addressed reference memory model,
// directed spec scenarios followed by randomized traffic with random back-pressure.
module tb_mem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk      (clk),
    .clr      (clr),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_func3(req_func3),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          vis;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mb [DEPTH*4];
  int          cyc = 0;
  int          last_hs = -100;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rsp_mode = 1;  // 0: hold low, 1: always take, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: memory as bytes, little endian, access size from func3[1:0].
  task automatic model_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int unsigned sz;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    e  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3[2]) ||
         ((a % sz) != 0) || (a >= 32'(DEPTH*4));
    rd = '0;
    if (!e) begin
      if (wr) begin
        for (int unsigned i = 0; i < sz; i++) mb[a+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int unsigned i = 0; i < sz; i++) v = v | (32'(mb[a+i]) << (8*i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following acceptance.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    exp_t x;
    int   waited = 0;
    req_write = wr;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (waited > 0) chk("accept_after_handshake", 32'(cyc + 1), 32'(last_hs + 1));
    model_op(wr, f3, a, wd, x.rdata, x.err);
    x.vis = cyc + 1 + LATENCY;
    sbq.push_back(x);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_func3 = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || !req_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rsp_mode == 2) rsp_ready = 1'($urandom);
      else rsp_ready = (rsp_mode == 1);
    end
  end

  // Monitor: first cycle of each response pops the scoreboard; later cycles check stability.
  initial begin
    logic        seen = 1'b0;
    exp_t        cur;
    forever begin
      @(negedge clk);
      if (clr) begin
        seen = 1'b0;
      end else if (rsp_valid) begin
        if (!seen) begin
          if (sbq.size() == 0) begin
            chk("unexpected_response", 32'd1, 32'd0);
            cur.rdata = rsp_rdata;
            cur.err   = rsp_err;
          end else begin
            cur = sbq.pop_front();
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(cur.err));
            chk("rsp_latency_cycle", 32'(cyc), 32'(cur.vis));
          end
          seen = 1'b1;
        end else begin
          chk("rsp_rdata_stable", rsp_rdata, cur.rdata);
          chk("rsp_err_stable", 32'(rsp_err), 32'(cur.err));
        end
        chk("req_ready_low_in_resp", 32'(req_ready), 32'd0);
        if (rsp_ready) begin
          last_hs = cyc + 1;
          seen    = 1'b0;
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    int          n;
    clr       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_func3 = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    do_req(1'b1, 3'b010, 32'h20, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h21, 32'h000000AA);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    do_req(1'b0, 3'b000, 32'h21, 32'h0);
    do_req(1'b0, 3'b100, 32'h21, 32'h0);
    do_req(1'b0, 3'b001, 32'h22, 32'h0);
    do_req(1'b0, 3'b010, 32'h22, 32'h0);
    do_req(1'b1, 3'b001, 32'h23, 32'h0000BEEF);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    do_req(1'b0, 3'b010, 32'(DEPTH*4), 32'h0);
    do_req(1'b1, 3'b100, 32'h24, 32'h0);
    do_req(1'b0, 3'b011, 32'h24, 32'h0);
    do_req(1'b1, 3'b010, 32'h30, 32'h12345678);
    wait_drain();

    // Reset while the store is still in its wait states.
    req_write = 1'b1;
    req_func3 = 3'b010;
    req_addr  = 32'h30;
    req_wdata = 32'h00000055;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    clr       = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_wait_req_ready", 32'(req_ready), 32'd1);
    chk("clr_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 3'b010, 32'h30, 32'h0);
    wait_drain();

    // Back-pressure: response held for at least 5 cycles.
    rsp_mode  = 0;
    rsp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    repeat (LATENCY + 5) @(posedge clk);
    #1;
    chk("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
    chk("bp_req_ready_low", 32'(req_ready), 32'd0);
    rsp_mode  = 1;
    rsp_ready = 1'b1;
    do_req(1'b0, 3'b101, 32'h22, 32'h0);
    wait_drain();

    for (int unsigned w = 0; w < 16; w++) do_req(1'b1, 3'b010, 32'(w*4), $urandom);
    rsp_mode = 2;
    for (int k = 0; k < 200; k++) begin
      n  = int'($urandom_range(0, 9));
      a  = (n == 0) ? 32'(DEPTH*4) + $urandom_range(0, 255) : $urandom_range(0, 63);
      f3 = 3'($urandom_range(0, 7));
      do_req(1'($urandom), f3, a, $urandom);
    end
    rsp_mode = 1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
